// File: rtl/response_sender_if.sv
// Byte-level handshake bundle between the frame source, response_sender and the UART TX.
// master drives the requests and tx_done; slave is the response_sender itself.
interface response_sender_if;
    logic       send;
    logic [7:0] response_code;
    logic [7:0] response_data;
    logic       tx_done;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       done;
    logic       error;
    logic [2:0] debug_state;

    modport master (
        output send, response_code, response_data, tx_done,
        input  tx_start, tx_data, busy, done, error, debug_state
    );

    modport slave (
        input  send, response_code, response_data, tx_done,
        output tx_start, tx_data, busy, done, error, debug_state
    );
endinterface

// File: rtl/response_sender.sv
// Serialises a 2-byte response frame (code, then data) into a UART TX byte port,
// pacing bytes on tx_done with a programmable gap and aborting on transmitter timeout.
module response_sender #(
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic              clock,
    input  logic              reset,
    response_sender_if.slave  bus
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_CODE = 3'd1,
        WAIT_CODE = 3'd2,
        GAP       = 3'd3,
        SEND_DATA = 3'd4,
        WAIT_DATA = 3'd5,
        FINISH    = 3'd6,
        ABORT     = 3'd7
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       data_q;
    logic             tx_start_q;
    logic [7:0]       tx_data_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;

    // Outputs are the registers themselves; tx_start is high exactly while in SEND_*.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            data_q     <= 8'h00;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every branch below sees pre-edge values
            // and the one-cycle pulses default low unless a branch re-arms them.
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.send) begin
                        data_q     <= bus.response_data;
                        tx_data_q  <= bus.response_code;
                        tx_start_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state      <= SEND_CODE;
                    end
                end

                SEND_CODE: begin
                    cnt   <= '0;
                    state <= WAIT_CODE;
                end

                WAIT_CODE: begin
                    if (bus.tx_done) begin
                        cnt <= '0;
                        if (GAP_CYCLES == 0) begin
                            tx_data_q  <= data_q;
                            tx_start_q <= 1'b1;
                            state      <= SEND_DATA;
                        end else begin
                            state <= GAP;
                        end
                    end else if (cnt == TIMEOUT_LAST) begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= ABORT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                GAP: begin
                    if (cnt == GAP_LAST) begin
                        tx_data_q  <= data_q;
                        tx_start_q <= 1'b1;
                        state      <= SEND_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                SEND_DATA: begin
                    cnt   <= '0;
                    state <= WAIT_DATA;
                end

                // tx_done is checked before the timeout so a same-cycle tie completes the byte.
                WAIT_DATA: begin
                    if (bus.tx_done) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= FINISH;
                    end else if (cnt == TIMEOUT_LAST) begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= ABORT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                FINISH:  state <= IDLE;
                ABORT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx_start    = tx_start_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.error       = error_q;
    assign bus.debug_state = state;

endmodule

// File: tb/tb_response_sender.sv
// Bench for response_sender: a timeline model predicts every tx_start/done/error cycle
// from send time and TX delays; a behavioural TX answers tx_start after a chosen delay.
module tb_response_sender;

    localparam int GAP = 2;
    localparam int TO  = 20;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    response_sender_if a_if ();
    response_sender_if b_if ();

    response_sender #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) u_dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (a_if.slave)
    );

    response_sender #(.GAP_CYCLES(0), .TIMEOUT_CYCLES(TO)) u_dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (b_if.slave)
    );

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    int         qs_cyc[$];
    logic [7:0] qs_dat[$];
    int         qd[$];
    int         qe[$];
    int         busy_cnt = 0;
    int         dly_q[$];

    // Event recorder for instance A, stamped with the cycle in which each output is high.
    always @(negedge clock) begin
        if (!reset) begin
            if (a_if.tx_start === 1'b1) begin
                qs_cyc.push_back(cyc);
                qs_dat.push_back(a_if.tx_data);
            end
            if (a_if.done === 1'b1)  qd.push_back(cyc);
            if (a_if.error === 1'b1) qe.push_back(cyc);
            if (a_if.busy === 1'b1)  busy_cnt++;
        end
    end

    // Behavioural transmitter: tx_done d cycles after each tx_start; d <= 0 means never.
    initial begin
        a_if.tx_done = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset && a_if.tx_start === 1'b1) begin
                int d;
                d = (dly_q.size() > 0) ? dly_q.pop_front() : 10;
                if (d > 0) begin
                    repeat (d) @(negedge clock);
                    a_if.tx_done = 1'b1;
                    @(negedge clock);
                    a_if.tx_done = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int start_at(input int idx);
        return (idx < qs_cyc.size()) ? qs_cyc[idx] : -1;
    endfunction

    function automatic logic [7:0] data_at(input int idx);
        return (idx < qs_dat.size()) ? qs_dat[idx] : 8'hxx;
    endfunction

    // Frame timeline from send cycle c and TX delays; -1 marks an event that must not happen.
    task automatic model(input int c, input int d0, input int d1,
                         output int s0, output int s1, output int fin, output int err);
        s0 = c + 1;
        if (d0 <= 0 || d0 > TO) begin
            s1 = -1; fin = -1; err = s0 + TO + 1;
        end else begin
            s1 = s0 + d0 + GAP + 1;
            if (d1 <= 0 || d1 > TO) begin
                fin = -1; err = s1 + TO + 1;
            end else begin
                fin = s1 + d1 + 1; err = -1;
            end
        end
    endtask

    task automatic clear_log();
        qs_cyc.delete(); qs_dat.delete(); qd.delete(); qe.delete();
        dly_q.delete();
        busy_cnt = 0;
    endtask

    task automatic run_frame(input logic [7:0] code, input logic [7:0] data,
                             input int d0, input int d1, input int rej_off, input string tag);
        int c, s0, s1, fin, err, endc;
        bit ended;
        clear_log();
        dly_q.push_back(d0);
        dly_q.push_back(d1);
        @(negedge clock);
        a_if.send = 1'b1; a_if.response_code = code; a_if.response_data = data;
        c = cyc;
        @(negedge clock);
        a_if.send = 1'b0;
        a_if.response_code = 8'($urandom);
        a_if.response_data = 8'($urandom);
        ended = 1'b0;
        for (int k = 0; k < 120 && !ended; k++) begin
            if (rej_off > 0 && cyc == c + rej_off) begin
                check({tag, "_rej_state"}, 32'(a_if.debug_state), 32'd2);
                a_if.send = 1'b1; a_if.response_code = 8'h05; a_if.response_data = 8'h77;
            end else begin
                a_if.send = 1'b0;
            end
            @(negedge clock);
            if (qd.size() > 0 || qe.size() > 0) ended = 1'b1;
        end
        a_if.send = 1'b0;
        repeat (3) @(negedge clock);

        model(c, d0, d1, s0, s1, fin, err);
        endc = (fin >= 0) ? fin : err;
        check({tag, "_ended"}, 32'(ended), 32'd1);
        check({tag, "_n_start"}, 32'(qs_cyc.size()), (s1 < 0) ? 32'd1 : 32'd2);
        check({tag, "_s0_cyc"}, start_at(0), s0);
        check({tag, "_s0_data"}, 32'(data_at(0)), 32'(code));
        if (s1 >= 0) begin
            check({tag, "_s1_cyc"}, start_at(1), s1);
            check({tag, "_s1_data"}, 32'(data_at(1)), 32'(data));
        end
        check({tag, "_n_done"}, 32'(qd.size()), (fin >= 0) ? 32'd1 : 32'd0);
        check({tag, "_n_err"}, 32'(qe.size()), (err >= 0) ? 32'd1 : 32'd0);
        if (fin >= 0) check({tag, "_done_cyc"}, (qd.size() > 0) ? qd[0] : -1, fin);
        if (err >= 0) check({tag, "_err_cyc"}, (qe.size() > 0) ? qe[0] : -1, err);
        check({tag, "_busy_len"}, busy_cnt, endc - s0);
        check({tag, "_idle_busy"}, 32'(a_if.busy), 32'd0);
        check({tag, "_idle_state"}, 32'(a_if.debug_state), 32'd0);
    endtask

    initial begin
        int c, s0a, s1a, fin1, erra, s0b, s1b, fin2, errb, t;
        bit hit;

        a_if.send = 1'b0; a_if.response_code = 8'h00; a_if.response_data = 8'h00;
        b_if.send = 1'b0; b_if.response_code = 8'h00; b_if.response_data = 8'h00;
        b_if.tx_done = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clock);

        check("rst_tx_start", 32'(a_if.tx_start), 32'd0);
        check("rst_tx_data", 32'(a_if.tx_data), 32'h00);
        check("rst_busy", 32'(a_if.busy), 32'd0);
        check("rst_done", 32'(a_if.done), 32'd0);
        check("rst_error", 32'(a_if.error), 32'd0);
        check("rst_state", 32'(a_if.debug_state), 32'd0);
        check("rst_b_state", 32'(b_if.debug_state), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        run_frame(8'h01, 8'h1A, 10, 10, 0, "nominal");
        run_frame(8'h01, 8'h1A, 10, 10, 4, "busy_rej");
        run_frame(8'($urandom), 8'($urandom), 0, 0, 0, "timeout0");
        run_frame(8'($urandom), 8'($urandom), 5, 0, 0, "timeout1");
        run_frame(8'($urandom), 8'($urandom), TO, TO, 0, "tie_edge");
        run_frame(8'($urandom), 8'($urandom), 1, 1, 0, "min_dly");

        // Reset asserted while instance A sits in GAP.
        clear_log();
        dly_q.push_back(10);
        dly_q.push_back(10);
        @(negedge clock);
        a_if.send = 1'b1; a_if.response_code = 8'h01; a_if.response_data = 8'h1A;
        @(negedge clock);
        a_if.send = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            @(negedge clock);
            if (a_if.debug_state === 3'd3) hit = 1'b1;
        end
        check("mid_rst_reach_gap", 32'(hit), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_tx_start", 32'(a_if.tx_start), 32'd0);
        check("mid_rst_tx_data", 32'(a_if.tx_data), 32'h00);
        check("mid_rst_busy", 32'(a_if.busy), 32'd0);
        check("mid_rst_done", 32'(a_if.done), 32'd0);
        check("mid_rst_error", 32'(a_if.error), 32'd0);
        check("mid_rst_state", 32'(a_if.debug_state), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check("post_rst_state", 32'(a_if.debug_state), 32'd0);
        check("post_rst_n_start", 32'(qs_cyc.size()), 32'd1);
        run_frame(8'h02, 8'h33, 10, 10, 0, "after_rst");

        // Back-to-back: send held high across two frames.
        clear_log();
        repeat (4) dly_q.push_back(10);
        @(negedge clock);
        a_if.send = 1'b1; a_if.response_code = 8'hAA; a_if.response_data = 8'h55;
        c = cyc;
        hit = 1'b0;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(negedge clock);
            if (qs_cyc.size() >= 3) hit = 1'b1;
        end
        a_if.send = 1'b0;
        check("b2b_third_start", 32'(hit), 32'd1);
        hit = 1'b0;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(negedge clock);
            if (qd.size() >= 2) hit = 1'b1;
        end
        check("b2b_second_done", 32'(hit), 32'd1);
        repeat (3) @(negedge clock);
        model(c, 10, 10, s0a, s1a, fin1, erra);
        model(fin1 + 1, 10, 10, s0b, s1b, fin2, errb);
        check("b2b_n_start", 32'(qs_cyc.size()), 32'd4);
        check("b2b_n_done", 32'(qd.size()), 32'd2);
        check("b2b_done0_cyc", (qd.size() > 0) ? qd[0] : -1, fin1);
        check("b2b_f2_s0_cyc", start_at(2), s0b);
        check("b2b_f2_s1_cyc", start_at(3), s1b);
        check("b2b_done1_cyc", (qd.size() > 1) ? qd[1] : -1, fin2);
        check("b2b_d0", 32'(data_at(0)), 32'hAA);
        check("b2b_d1", 32'(data_at(1)), 32'h55);
        check("b2b_d2", 32'(data_at(2)), 32'hAA);
        check("b2b_d3", 32'(data_at(3)), 32'h55);

        for (int i = 0; i < 6; i++) begin
            run_frame(8'($urandom), 8'($urandom), int'($urandom_range(1, TO)),
                      int'($urandom_range(1, TO)), 0, $sformatf("rand%0d", i));
        end

        // GAP_CYCLES=0 instance: byte1 follows byte0's tx_done by one cycle.
        @(negedge clock);
        b_if.send = 1'b1; b_if.response_code = 8'h3C; b_if.response_data = 8'hC3;
        @(negedge clock);
        b_if.send = 1'b0;
        check("g0_s0_start", 32'(b_if.tx_start), 32'd1);
        check("g0_s0_data", 32'(b_if.tx_data), 32'h3C);
        check("g0_busy", 32'(b_if.busy), 32'd1);
        repeat (4) @(negedge clock);
        b_if.tx_done = 1'b1;
        t = cyc;
        check("g0_pre_start", 32'(b_if.tx_start), 32'd0);
        @(negedge clock);
        b_if.tx_done = 1'b0;
        check("g0_s1_delay", cyc - t, 32'd1);
        check("g0_s1_start", 32'(b_if.tx_start), 32'd1);
        check("g0_s1_data", 32'(b_if.tx_data), 32'hC3);
        check("g0_s1_state", 32'(b_if.debug_state), 32'd4);
        repeat (2) @(negedge clock);
        b_if.tx_done = 1'b1;
        @(negedge clock);
        b_if.tx_done = 1'b0;
        check("g0_done", 32'(b_if.done), 32'd1);
        check("g0_done_busy", 32'(b_if.busy), 32'd0);
        @(negedge clock);
        check("g0_idle_state", 32'(b_if.debug_state), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
